ram_sdp_param: RTL and testbench

//  Parametrised simple-dual-port RAM: one write port and one read port, both on one clock.

---
 rtl/ram_sdp_param.sv | 90 +++++++++
 tb/tb_ram_sdp_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_param.sv
// ram_sdp_param: simple-dual-port RAM with byte enables, 1/2-cycle read latency and a hardware clear FSM.
module ram_sdp_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int OUT_REG  = 0,
    parameter int RDW_MODE = 0,
    localparam int ADDR_W  = $clog2(DEPTH),
    localparam int NB      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [NB-1:0]     wr_be,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              clr_req,
    output logic              clr_busy
);
    typedef enum logic {CLEAR, RUN} state_t;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    state_t              state, state_nx;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_word;
    logic                wr_ok, rd_acc, rd_in;
    assign wr_ok  = cs && wr_en && state == RUN && {1'b0, wr_addr} < DEPTH_L;
    assign rd_acc = cs && rd_en && state == RUN;
    assign rd_in  = {1'b0, rd_addr} < DEPTH_L;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= (state == CLEAR && clr_cnt != LAST) ? clr_cnt + ADDR_W'(1) : '0;
        end
    end
    always_comb state_nx = (state == CLEAR) ? ((clr_cnt == LAST) ? RUN : CLEAR) : (clr_req ? CLEAR : RUN);
    always_comb clr_busy = state == CLEAR;
    // The array itself has no reset; the CLEAR sweep zeroes it one word per cycle.
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_cnt] <= '0;
        else if (wr_ok)
            for (int i = 0; i < NB; i++)
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
    // Out-of-range reads return zero; in new-data mode a colliding write is merged byte-wise.
    always_comb begin
        rd_word = rd_in ? mem[rd_addr] : '0;
        if (RDW_MODE != 0 && wr_ok && wr_addr == rd_addr)
            for (int i = 0; i < NB; i++)
                if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
    end
    generate
        if (OUT_REG != 0) begin : g_reg
            logic              p_valid;
            logic [DATA_W-1:0] p_data;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_valid  <= 1'b0;
                    p_data   <= '0;
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    p_valid  <= rd_acc;
                    if (rd_acc) p_data <= rd_word;
                    rd_valid <= p_valid;
                    if (p_valid) rd_data <= p_data;
                end
            end
        end else begin : g_dir
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_valid <= 1'b0;
                    rd_data  <= '0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc) rd_data <= rd_word;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_ram_sdp_param.sv
// tb_ram_sdp_param: scoreboard bench driving two RAM configurations (latency 1/old-data, latency 2/new-data).
module tb_ram_sdp_param;
    localparam int DW = 32;
    localparam int D  = 12;
    localparam int AW = 4;
    localparam int NB = 4;
    logic clk = 0, rst = 1, cs = 0, wr_en = 0, rd_en = 0, clr_req = 0;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [NB-1:0] wr_be = '0;
    logic [DW-1:0] rd_data0, rd_data1;
    logic rd_valid0, rd_valid1, busy0, busy1;
    int cyc = 0;
    int vecs = 0, errs = 0;
    typedef struct {logic [DW-1:0] d; int due;} exp_t;
    exp_t q0[$], q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_sdp_param #(.DATA_W(DW), .DEPTH(D), .OUT_REG(0), .RDW_MODE(0)) u0 (
        .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0),
        .clr_req(clr_req), .clr_busy(busy0));
    ram_sdp_param #(.DATA_W(DW), .DEPTH(D), .OUT_REG(1), .RDW_MODE(1)) u1 (
        .clk(clk), .rst(rst), .cs(cs), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .clr_req(clr_req), .clr_busy(busy1));

    always @(negedge clk) if (!rst && rd_valid0) begin
        vecs++;
        if (q0.size() == 0) begin
            errs++;
            $display("FAIL u0 unexpected rd_valid: data %h at cycle %0d", rd_data0, cyc);
        end else begin
            e0 = q0.pop_front();
            if (rd_data0 !== e0.d || cyc != e0.due) begin
                errs++;
                $display("FAIL u0 read: got %h at cycle %0d, expected %h at cycle %0d", rd_data0, cyc, e0.d, e0.due);
            end
        end
    end

    always @(negedge clk) if (!rst && rd_valid1) begin
        vecs++;
        if (q1.size() == 0) begin
            errs++;
            $display("FAIL u1 unexpected rd_valid: data %h at cycle %0d", rd_data1, cyc);
        end else begin
            e1 = q1.pop_front();
            if (rd_data1 !== e1.d || cyc != e1.due) begin
                errs++;
                $display("FAIL u1 read: got %h at cycle %0d, expected %h at cycle %0d", rd_data1, cyc, e1.d, e1.due);
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic op(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [NB-1:0] be,
                      input bit r, input logic [AW-1:0] ra, input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                      input bit c);
        cs = 1; wr_en = w; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = r; rd_addr = ra; clr_req = c;
        if (r) begin
            q0.push_back('{x0, cyc + 1});
            q1.push_back('{x1, cyc + 2});
        end
        @(negedge clk);
        cs = 0; wr_en = 0; rd_en = 0; clr_req = 0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        op(1, a, d, be, 0, '0, '0, '0, 0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] x);
        op(0, '0, '0, '0, 1, a, x, x, 0);
    endtask

    task automatic wait_clear(input string name);
        int n = 0;
        while (busy0 && n < 4 * D) begin
            n++;
            @(negedge clk);
        end
        chk(name, 32'(n), 32'(D));
        chk({name, " u1 idle"}, 32'(busy1), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset rd_valid0", 32'(rd_valid0), 32'd0);
        chk("reset rd_data0", rd_data0, 32'd0);
        chk("reset busy0", 32'(busy0), 32'd1);
        chk("reset rd_valid1", 32'(rd_valid1), 32'd0);
        chk("reset rd_data1", rd_data1, 32'd0);
        chk("reset busy1", 32'(busy1), 32'd1);
        rst = 0;
        wait_clear("initial clear cycles");
        for (int a = 0; a < 16; a++) rd(AW'(a), 32'd0);
        wr(4'd5, 32'hDEADBEEF, 4'b1111);
        wr(4'd5, 32'h00AA0000, 4'b0100);
        rd(4'd5, 32'hDEAABEEF);
        wr(4'd13, 32'hFFFFFFFF, 4'b1111);
        rd(4'd13, 32'd0);
        wr(4'd9, 32'h11111111, 4'b1111);
        op(1, 4'd9, 32'h22222222, 4'b1111, 1, 4'd9, 32'h11111111, 32'h22222222, 0);
        rd(4'd9, 32'h22222222);
        wr(4'd10, 32'h11111111, 4'b1111);
        op(1, 4'd10, 32'hAABBCCDD, 4'b0101, 1, 4'd10, 32'h11111111, 32'h11BB11DD, 0);
        rd(4'd10, 32'h11BB11DD);
        wr(4'd10, 32'h00000000, 4'b0000);
        wr_en = 1; rd_en = 1; wr_addr = 4'd10; wr_data = '0; wr_be = '1; rd_addr = 4'd10;
        @(negedge clk);
        wr_en = 0; rd_en = 0;
        rd(4'd10, 32'h11BB11DD);
        for (int k = 0; k < 8; k++) wr(AW'(k), 32'(k) * 32'h01010101, 4'b1111);
        for (int k = 0; k < 8; k++) rd(AW'(k), 32'(k) * 32'h01010101);
        op(1, 4'd3, 32'h12345678, 4'b1111, 1, 4'd7, 32'h07070707, 32'h07070707, 1);
        n = 0;
        while (busy0 && n < 4 * D) begin
            n++;
            cs = 1; wr_en = 1; wr_addr = 4'd0; wr_data = '1; wr_be = '1;
            rd_en = 1; rd_addr = 4'd0; clr_req = (n == 3);
            @(negedge clk);
        end
        cs = 0; wr_en = 0; rd_en = 0; clr_req = 0;
        chk("clr_req clear cycles", 32'(n), 32'(D));
        rd(4'd3, 32'd0);
        rd(4'd0, 32'd0);
        rd(4'd7, 32'd0);
        wr(4'd6, 32'h66666666, 4'b1111);
        cs = 1; rd_en = 1; rd_addr = 4'd6;
        @(posedge clk);
        #2;
        cs = 0; rd_en = 0;
        rst = 1;
        #1;
        chk("async reset rd_valid0", 32'(rd_valid0), 32'd0);
        chk("async reset rd_valid1", 32'(rd_valid1), 32'd0);
        chk("async reset busy0", 32'(busy0), 32'd1);
        @(negedge clk);
        rst = 0;
        repeat (5) @(negedge clk);
        chk("mid-clear busy1", 32'(busy1), 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        wait_clear("clear after reset cycles");
        rd(4'd6, 32'd0);
        repeat (4) @(negedge clk);
        chk("u0 queue drained", 32'(q0.size()), 32'd0);
        chk("u1 queue drained", 32'(q1.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
